// File: rtl/switch_bounce_gen.sv
// switch_bounce_gen: mechanical-switch emulator for debounce-filter self-test.
// Each command change produces an LFSR-timed odd-length toggle burst followed by a settle hold.
module switch_bounce_gen #(
    parameter int unsigned c_PAIRS_W = 3,
    parameter int unsigned c_GAP_MIN = 1000,
    parameter int unsigned c_GAP_W   = 12,
    parameter int unsigned c_SETTLE  = 500000,
    parameter logic [15:0] c_SEED    = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_switch,
    output logic o_switch,
    output logic o_busy,
    output logic o_done
);

    localparam int unsigned          c_LEFT_W    = c_PAIRS_W + 1;
    localparam logic [19:0]          c_GAP_BASE  = 20'(c_GAP_MIN - 1);
    localparam logic [19:0]          c_SETTLE_LD = 20'(c_SETTLE - 1);
    localparam logic [c_LEFT_W-1:0]  c_LEFT_ONE  = c_LEFT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE,
        SETTLE
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic                  sw_q, sw_d;
    logic                  target_q, target_d;
    logic                  done_q, done_d;
    logic [c_LEFT_W-1:0]   left_q, left_d;
    logic [19:0]           cnt_q, cnt_d;
    logic [c_PAIRS_W-1:0]  pairs;
    logic [c_GAP_W-1:0]    gap_ext;

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0; free-running.
    assign lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign pairs   = lfsr_q[c_PAIRS_W-1:0];
    assign gap_ext = lfsr_q[15 -: c_GAP_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            lfsr_q   <= c_SEED;
            sw_q     <= 1'b0;
            target_q <= 1'b0;
            done_q   <= 1'b0;
            left_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            sw_q     <= sw_d;
            target_q <= target_d;
            done_q   <= done_d;
            left_q   <= left_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sw_d     = sw_q;
        target_d = target_q;
        left_d   = left_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;

        // A new command restarts from any state and pre-empts both a due toggle and o_done.
        if (i_switch != target_q) begin
            target_d = i_switch;
            left_d   = {pairs, 1'b1};
            cnt_d    = '0;
            state_d  = BOUNCE;
        end else begin
            case (state_q)
                BOUNCE: begin
                    if (cnt_q == '0) begin
                        left_d = left_q - c_LEFT_ONE;
                        if (left_q == c_LEFT_ONE) begin
                            sw_d    = target_q;
                            cnt_d   = c_SETTLE_LD;
                            state_d = SETTLE;
                        end else begin
                            sw_d  = ~sw_q;
                            cnt_d = c_GAP_BASE + 20'(gap_ext);
                        end
                    end else begin
                        cnt_d = cnt_q - 20'd1;
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 20'd1;
                    end
                end
                IDLE:    ;
                default: state_d = IDLE;
            endcase
        end
    end

    assign o_switch = sw_q;
    assign o_busy   = (state_q != IDLE);
    assign o_done   = done_q;

endmodule
